// File: rtl/trace_packetiser.sv
// Trace record packetiser: buffers writeback trace records in a small FIFO and
// streams each one as a sequence-numbered header beat plus N payload beats.
package ryuki_datatypes;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        trap;
    logic [3:0]  cause;
  } trace_output;

endpackage

module trace_packetiser
  import ryuki_datatypes::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_data_ready,
  input  trace_output                   wb_data_i,
  output logic                          out_valid,
  output logic [WORD_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int unsigned REC_W    = $bits(trace_output);
  localparam int unsigned N_BEATS  = (REC_W + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned PAD_W    = N_BEATS * WORD_WIDTH;
  localparam int unsigned ENTRY_W  = 16 + REC_W;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned IDX_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;

  logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [15:0]            seq_q;
  logic                   overflow_q;
  logic [15:0]            drop_q;

  logic                   handshake, pop, full, accept, drop;
  logic [ENTRY_W-1:0]     sel_entry;

  function automatic logic [WORD_WIDTH-1:0] header_beat(input logic [15:0] seq);
    logic [WORD_WIDTH-1:0] h;
    h        = '0;
    h[31:16] = seq;
    h[15:0]  = 16'(N_BEATS);
    return h;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] payload_beat(input logic [REC_W-1:0] rec,
                                                         input logic [IDX_W-1:0] k);
    logic [PAD_W-1:0] padded;
    padded = PAD_W'(rec);
    return padded[k*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  assign handshake = out_valid_q & out_ready;
  // out_last is only ever raised on the final payload beat, so it alone marks the pop.
  assign pop       = handshake & out_last_q;
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign accept    = wb_data_ready & (~full | pop);
  assign drop      = wb_data_ready & full & ~pop;
  assign sel_entry = mem_q[pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (wb_data_ready) seq_q <= seq_q + 16'd1;
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wr_ptr_q] <= {seq_q, wb_data_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (handshake) begin
          state_d = S_PAYLOAD;
          idx_d   = '0;
        end
      end
      S_PAYLOAD: begin
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            state_d = (count_q > CNT_W'(1)) ? S_HEADER : S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next beat is precomputed from the next state so the outputs stay registered.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (!(out_valid_q && !out_ready)) begin
      out_valid_d = (state_d != S_IDLE);
      out_last_d  = (state_d == S_PAYLOAD) && (idx_d == LAST_IDX);
      unique case (state_d)
        S_HEADER:  out_data_d = header_beat(sel_entry[ENTRY_W-1 -: 16]);
        S_PAYLOAD: out_data_d = payload_beat(sel_entry[REC_W-1:0], idx_d);
        default:   out_data_d = '0;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trace_packetiser.sv
// Scoreboard bench for trace_packetiser: stimulus queues expected beats, a
// negedge monitor pops and compares every handshaken beat.
module tb_trace_packetiser;
  import ryuki_datatypes::*;

  localparam int unsigned WW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = $bits(trace_output);
  localparam int unsigned NB    = (RW + WW - 1) / WW;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_data_ready;
  trace_output       wb_data_i;
  logic              out_valid;
  logic [WW-1:0]     out_data;
  logic              out_last;
  logic              out_ready;
  logic [2:0]        fifo_level;
  logic              overflow;
  logic [15:0]       drop_count;

  always #5 clk = ~clk;

  trace_packetiser #(.FIFO_DEPTH(DEPTH), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .wb_data_ready(wb_data_ready), .wb_data_i(wb_data_i),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] seq_m;
  logic [15:0] drops_m;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic trace_output mk(input int unsigned i);
    trace_output r;
    r.pc      = 32'h8000_0000 + 32'(i) * 32'd4;
    r.instr   = 32'hDEAD_0013 ^ {16'(i), 16'h0000};
    r.rd_wen  = i[0];
    r.rd_addr = 5'(i + 1);
    r.rd_data = 32'hA5A5_0000 | 32'(i * 17);
    r.trap    = i[1];
    r.cause   = 4'(i + 3);
    return r;
  endfunction

  function automatic logic [31:0] pay(input trace_output r, input int unsigned k);
    logic [NB*WW-1:0] p;
    p         = '0;
    p[RW-1:0] = r;
    return p[k*WW +: WW];
  endfunction

  task automatic expect_rec(input trace_output r);
    sb.push_back(beat_t'{data: {seq_m, 16'(NB)}, last: 1'b0});
    for (int unsigned k = 0; k < NB; k++)
      sb.push_back(beat_t'{data: pay(r, k), last: (k == NB - 1)});
  endtask

  task automatic push(input trace_output r, input bit accepted);
    wb_data_i     = r;
    wb_data_ready = 1'b1;
    if (accepted) expect_rec(r);
    else drops_m++;
    seq_m++;
    tick();
    wb_data_ready = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain", {63'd0, (sb.size() == 0 && !out_valid)}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(out_valid && out_data == prev_data && out_last == prev_last)) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got d=%0h l=%0b expected no beat", out_data, out_last);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL beat: got d=%0h l=%0b expected d=%0h l=%0b",
                     out_data, out_last, e.data, e.last);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int peak, run, best;
    rst = 1'b1; wb_data_ready = 1'b0; wb_data_i = '0; out_ready = 1'b1;
    seq_m = '0; drops_m = '0;
    tick(); tick(); tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_level", {61'd0, fifo_level}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_drops", {48'd0, drop_count}, 64'd0);
    rst = 1'b0;
    tick();

    // Single record with latency check
    push(mk(1), 1'b1);
    chk("lat_level", {61'd0, fifo_level}, 64'd1);
    chk("lat_idle", {63'd0, out_valid}, 64'd0);
    tick();
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_hdr", {32'd0, out_data}, {32'd0, 16'h0000, 16'(NB)});
    chk("lat_hdr_last", {63'd0, out_last}, 64'd0);
    wait_drain();

    // Back-to-back records two cycles apart
    peak = 0; run = 0; best = 0;
    fork
      begin
        push(mk(2), 1'b1); tick();
        push(mk(3), 1'b1); tick();
        push(mk(4), 1'b1);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (int'(fifo_level) > peak) peak = int'(fifo_level);
          if (out_valid) run++;
          else begin
            if (run > best) best = run;
            run = 0;
          end
        end
        if (run > best) best = run;
      end
    join
    chk("b2b_peak", 64'(peak), 64'd3);
    chk("b2b_nogap", 64'(best), 64'(3 * (NB + 1)));
    wait_drain();

    // Backpressure on payload beat 1
    push(mk(5), 1'b1);
    tick(); tick(); tick();
    out_ready = 1'b0;
    chk("bp_beat1", {32'd0, out_data}, {32'd0, pay(mk(5), 1)});
    for (int i = 0; i < 20; i++) tick();
    chk("bp_hold", {32'd0, out_data}, {32'd0, pay(mk(5), 1)});
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    wait_drain();

    // Overflow: six pushes into a stalled four-deep FIFO
    rst = 1'b1; sb.delete(); seq_m = '0; drops_m = '0;
    tick(); rst = 1'b0;
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 6; i++) push(mk(10 + i), i < DEPTH);
    chk("ovf_level", {61'd0, fifo_level}, 64'd4);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_drops", {48'd0, drop_count}, {48'd0, drops_m});
    out_ready = 1'b1;
    wait_drain();
    push(mk(20), 1'b1);
    wait_drain();

    // Full FIFO with last beat handshaking in the same cycle as a push
    out_ready = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) push(mk(30 + i), 1'b1);
    chk("full_level", {61'd0, fifo_level}, 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_last) break;
      tick();
    end
    chk("full_at_last", {63'd0, out_last}, 64'd1);
    push(mk(40), 1'b1);
    chk("full_pop_level", {61'd0, fifo_level}, 64'd4);
    chk("full_pop_drops", {48'd0, drop_count}, {48'd0, drops_m});
    wait_drain();

    // Reset during payload beat 1, with a coincident record strobe
    push(mk(50), 1'b1);
    tick(); tick(); tick();
    rst = 1'b1; wb_data_ready = 1'b1; wb_data_i = mk(51);
    sb.delete(); seq_m = '0; drops_m = '0;
    tick();
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_data", {32'd0, out_data}, 64'd0);
    chk("mrst_level", {61'd0, fifo_level}, 64'd0);
    chk("mrst_drops", {48'd0, drop_count}, 64'd0);
    chk("mrst_ovf", {63'd0, overflow}, 64'd0);
    rst = 1'b0; wb_data_ready = 1'b0;
    tick();
    chk("mrst_ignored", {61'd0, fifo_level}, 64'd0);
    push(mk(52), 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
